// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front-end: button field layout,
// hps_io joystick bit positions, PS/2 set-2 scan codes and the coin FSM states.
package arcade_input_pkg;

  // Per-player button field layout (active-high)
  localparam int BTN_W     = 10;
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_FIREA = 4;
  localparam int BTN_FIREB = 5;
  localparam int BTN_FIREC = 6;
  localparam int BTN_FIRED = 7;
  localparam int BTN_START = 8;
  localparam int BTN_COIN  = 9;

  // hps_io joystick word layout (bits 0-7 map 1:1 onto the button field)
  localparam int JOY_W        = 16;
  localparam int JOY_START    = 8;
  localparam int JOY_START_P2 = 9;
  localparam int JOY_COIN     = 10;

  // Player 0 scan codes
  localparam logic [7:0] SC_P0_UP     = 8'h75;
  localparam logic [7:0] SC_P0_DOWN   = 8'h72;
  localparam logic [7:0] SC_P0_LEFT   = 8'h6B;
  localparam logic [7:0] SC_P0_RIGHT  = 8'h74;
  localparam logic [7:0] SC_P0_FIREA  = 8'h14;
  localparam logic [7:0] SC_P0_FIREB  = 8'h11;
  localparam logic [7:0] SC_P0_FIREC  = 8'h29;
  localparam logic [7:0] SC_P0_FIRED  = 8'h12;
  localparam logic [7:0] SC_P0_START0 = 8'h05;
  localparam logic [7:0] SC_P0_START1 = 8'h16;
  localparam logic [7:0] SC_P0_COIN0  = 8'h76;
  localparam logic [7:0] SC_P0_COIN1  = 8'h2E;

  // Player 1 scan codes
  localparam logic [7:0] SC_P1_UP     = 8'h2D;
  localparam logic [7:0] SC_P1_DOWN   = 8'h2B;
  localparam logic [7:0] SC_P1_LEFT   = 8'h23;
  localparam logic [7:0] SC_P1_RIGHT  = 8'h34;
  localparam logic [7:0] SC_P1_FIREA  = 8'h1C;
  localparam logic [7:0] SC_P1_FIREB  = 8'h1B;
  localparam logic [7:0] SC_P1_FIREC  = 8'h15;
  localparam logic [7:0] SC_P1_FIRED  = 8'h1D;
  localparam logic [7:0] SC_P1_START0 = 8'h06;
  localparam logic [7:0] SC_P1_START1 = 8'h1E;
  localparam logic [7:0] SC_P1_COIN   = 8'h36;

  // Coin pulse shaper states
  typedef enum logic [1:0] {
    CS_IDLE     = 2'd0,
    CS_PULSE    = 2'd1,
    CS_WAIT_REL = 2'd2
  } coin_state_t;

  // Result of looking a scan code up in the key maps
  typedef struct packed {
    logic       hit;
    logic       player;
    logic [3:0] idx;
  } key_map_t;

  // Scan code -> (player, button bit). Extended prefix is not an input here,
  // so keypad codes alias the arrow keys.
  function automatic key_map_t map_scan_code(input logic [7:0] code);
    key_map_t m;
    m.hit    = 1'b1;
    m.player = 1'b0;
    m.idx    = 4'd0;
    case (code)
      SC_P0_UP:     m.idx = 4'(BTN_UP);
      SC_P0_DOWN:   m.idx = 4'(BTN_DOWN);
      SC_P0_LEFT:   m.idx = 4'(BTN_LEFT);
      SC_P0_RIGHT:  m.idx = 4'(BTN_RIGHT);
      SC_P0_FIREA:  m.idx = 4'(BTN_FIREA);
      SC_P0_FIREB:  m.idx = 4'(BTN_FIREB);
      SC_P0_FIREC:  m.idx = 4'(BTN_FIREC);
      SC_P0_FIRED:  m.idx = 4'(BTN_FIRED);
      SC_P0_START0: m.idx = 4'(BTN_START);
      SC_P0_START1: m.idx = 4'(BTN_START);
      SC_P0_COIN0:  m.idx = 4'(BTN_COIN);
      SC_P0_COIN1:  m.idx = 4'(BTN_COIN);
      SC_P1_UP:     begin m.player = 1'b1; m.idx = 4'(BTN_UP);    end
      SC_P1_DOWN:   begin m.player = 1'b1; m.idx = 4'(BTN_DOWN);  end
      SC_P1_LEFT:   begin m.player = 1'b1; m.idx = 4'(BTN_LEFT);  end
      SC_P1_RIGHT:  begin m.player = 1'b1; m.idx = 4'(BTN_RIGHT); end
      SC_P1_FIREA:  begin m.player = 1'b1; m.idx = 4'(BTN_FIREA); end
      SC_P1_FIREB:  begin m.player = 1'b1; m.idx = 4'(BTN_FIREB); end
      SC_P1_FIREC:  begin m.player = 1'b1; m.idx = 4'(BTN_FIREC); end
      SC_P1_FIRED:  begin m.player = 1'b1; m.idx = 4'(BTN_FIRED); end
      SC_P1_START0: begin m.player = 1'b1; m.idx = 4'(BTN_START); end
      SC_P1_START1: begin m.player = 1'b1; m.idx = 4'(BTN_START); end
      SC_P1_COIN:   begin m.player = 1'b1; m.idx = 4'(BTN_COIN);  end
      default:      m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_shaper.sv
// Coin pulse shaper: each press produces exactly COIN_PULSE cycles of
// coin_out, independent of hold time; re-arms only after the coin is released.
module arcade_coin_shaper
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 500000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic coin_raw,
  output logic coin_out
);

  localparam int CNT_W = $clog2((COIN_PULSE > 2) ? COIN_PULSE : 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  coin_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and pulse counter registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= CS_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on press, count the pulse down, then wait for release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CS_IDLE: begin
        if (coin_raw) begin
          state_d = CS_PULSE;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = CS_IDLE;
          cnt_d   = cnt_q;
        end
      end
      CS_PULSE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = CS_WAIT_REL;
          cnt_d   = cnt_q;
        end else begin
          state_d = CS_PULSE;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      CS_WAIT_REL: begin
        if (!coin_raw) begin
          state_d = CS_IDLE;
        end else begin
          state_d = CS_WAIT_REL;
        end
      end
      default: begin
        state_d = CS_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: coin is high only while in the pulse state
  always_comb begin
    case (state_q)
      CS_PULSE: coin_out = 1'b1;
      default:  coin_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade input front-end: PS/2 key state for players 0/1, merged with the
// hps_io joysticks, coin pulse shaping and shared-phase autofire on fireA.
// Keyboard path: key state register, then btn register (2 edges).
// Joystick path: btn register only (1 edge).
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int COIN_PULSE  = 500000,
  parameter int AF_DIV      = 666666
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic [10:0]                  ps2_key,
  input  logic                         kbd_clear,
  input  logic [JOY_W*NUM_PLAYERS-1:0] joy,
  input  logic [NUM_PLAYERS-1:0]       af_en,
  output logic [BTN_W*NUM_PLAYERS-1:0] btn,
  output logic [BTN_W-1:0]             btn_any
);

  localparam int AF_W = $clog2((AF_DIV > 2) ? AF_DIV : 2);
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_DIV - 1);
  localparam logic [AF_W-1:0] AF_ZERO = AF_W'(0);
  localparam logic [AF_W-1:0] AF_ONE  = AF_W'(1);

  // PS/2 toggle tracking
  logic old_tog_q, old_tog_d;
  logic primed_q, primed_d;
  key_map_t key_map_s;
  logic unused_ext_s;

  // Keyboard key state, players 0 and 1 only
  logic [1:0][BTN_W-1:0] key_q, key_d;

  // Autofire timebase shared by all players
  logic [AF_W-1:0] af_cnt_q, af_cnt_d;
  logic            af_phase_q, af_phase_d;

  // Output stage
  logic [NUM_PLAYERS-1:0][BTN_W-1:0] btn_d, btn_q;
  logic [BTN_W-1:0]                  btn_any_d, btn_any_q;

  // The extended prefix is deliberately ignored so keypad codes alias arrows
  assign unused_ext_s = ps2_key[8];

  // Key event decode; kbd_clear overrides and consumes any simultaneous event
  always_comb begin
    key_map_s = map_scan_code(ps2_key[7:0]);
    old_tog_d = ps2_key[10];
    primed_d  = 1'b1;
    if (kbd_clear) begin
      key_d = '0;
    end else if (primed_q && (ps2_key[10] != old_tog_q) && key_map_s.hit) begin
      key_d = key_q;
      key_d[key_map_s.player][key_map_s.idx] = ps2_key[9];
    end else begin
      key_d = key_q;
    end
  end

  // Toggle tracking and key state registers; first edge after reset only primes
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      old_tog_q <= 1'b0;
      primed_q  <= 1'b0;
      key_q     <= '0;
    end else begin
      old_tog_q <= old_tog_d;
      primed_q  <= primed_d;
      key_q     <= key_d;
    end
  end

  // Autofire divider: free-running count, phase flips on each wrap
  always_comb begin
    if (af_cnt_q == AF_LAST) begin
      af_cnt_d   = AF_ZERO;
      af_phase_d = ~af_phase_q;
    end else begin
      af_cnt_d   = af_cnt_q + AF_ONE;
      af_phase_d = af_phase_q;
    end
  end

  // Autofire counter and phase registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      af_cnt_q   <= AF_ZERO;
      af_phase_q <= 1'b0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [BTN_W-1:0] key_s;
    logic [BTN_W-1:0] raw_s;
    logic [BTN_W-1:0] shaped_s;
    logic             p2_start_s;
    logic             coin_out_s;
    logic             unused_joy_s;

    if (p < 2) begin : g_kbd
      assign key_s = key_q[p];
    end else begin : g_no_kbd
      assign key_s = '0;
    end

    // Joystick 0 carries a second start button that belongs to player 1
    if (p == 1) begin : g_p2_start
      assign p2_start_s = joy[JOY_START_P2];
    end else begin : g_no_p2_start
      assign p2_start_s = 1'b0;
    end

    if ((p == 0) && (NUM_PLAYERS > 1)) begin : g_unused_hi
      assign unused_joy_s = ^joy[JOY_W*p+11 +: 5];
    end else begin : g_unused_hi_b9
      assign unused_joy_s = ^{joy[JOY_W*p+JOY_START_P2], joy[JOY_W*p+11 +: 5]};
    end

    // Raw per-player field: keyboard state OR'd with the remapped joystick
    always_comb begin
      raw_s            = key_s;
      raw_s[7:0]       = raw_s[7:0] | joy[JOY_W*p +: 8];
      raw_s[BTN_START] = raw_s[BTN_START] | joy[JOY_W*p+JOY_START] | p2_start_s;
      raw_s[BTN_COIN]  = raw_s[BTN_COIN] | joy[JOY_W*p+JOY_COIN];
    end

    arcade_coin_shaper #(
      .COIN_PULSE (COIN_PULSE)
    ) u_coin (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .coin_raw (raw_s[BTN_COIN]),
      .coin_out (coin_out_s)
    );

    // Post-shaping field: shaped coin, fireA gated by the autofire phase
    always_comb begin
      shaped_s           = raw_s;
      shaped_s[BTN_COIN] = coin_out_s;
      if (af_en[p]) begin
        shaped_s[BTN_FIREA] = raw_s[BTN_FIREA] & af_phase_q;
      end else begin
        shaped_s[BTN_FIREA] = raw_s[BTN_FIREA];
      end
    end

    assign btn_d[p] = shaped_s;
  end

  // OR of every player's shaped field, registered alongside btn
  always_comb begin
    btn_any_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      btn_any_d = btn_any_d | btn_d[i];
    end
  end

  // Output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      btn_q     <= '0;
      btn_any_q <= '0;
    end else begin
      btn_q     <= btn_d;
      btn_any_q <= btn_any_d;
    end
  end

  assign btn     = btn_q;
  assign btn_any = btn_any_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper with COIN_PULSE=4, AF_DIV=3.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
module tb_arcade_input_mapper;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [10:0] ps2_key;
  logic        kbd_clear;
  logic [31:0] joy;
  logic [1:0]  af_en;
  logic [19:0] btn;
  logic [9:0]  btn_any;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic tog;

  always #5 Clk = ~Clk;

  arcade_input_mapper #(
    .NUM_PLAYERS (2),
    .COIN_PULSE  (4),
    .AF_DIV      (3)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .ps2_key   (ps2_key),
    .kbd_clear (kbd_clear),
    .joy       (joy),
    .af_en     (af_en),
    .btn       (btn),
    .btn_any   (btn_any)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic key_ev(input logic [7:0] code, input logic pressed, input logic ext);
    tog     = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic count_coin(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      tick(1);
      if (btn[9]) hi++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hi, h1, h2, h3, h4, found;
    logic prev, v, exp_b;

    Rst_n     = 1'b0;
    tog       = 1'b1;
    ps2_key   = {1'b1, 1'b1, 1'b0, 8'h6B};
    kbd_clear = 1'b0;
    joy       = 32'h0;
    af_en     = 2'b00;

    #3;
    check_eq("reset_btn", btn, 32'h0);
    check_eq("reset_btn_any", btn_any, 32'h0);
    #9 Rst_n = 1'b1;

    // First edge only primes: held strobe=1 with 6B pressed is not an event
    tick(3);
    check_eq("primed_no_event", btn, 32'h0);

    // Left press: visible exactly 2 edges after the toggle
    key_ev(8'h6B, 1'b1, 1'b0);
    tick(1);
    check_eq("kbd_latency_1edge", btn[1], 32'h0);
    tick(1);
    check_eq("kbd_latency_2edge", btn[1], 32'h1);
    key_ev(8'h6B, 1'b0, 1'b0);
    tick(2);
    check_eq("left_release", btn, 32'h0);

    // Player 0 fireC and player 1 fireA, overlapping
    key_ev(8'h29, 1'b1, 1'b0);
    tick(2);
    check_eq("p0_fireC_btn", btn, 32'h00040);
    check_eq("p0_fireC_any", btn_any, 32'h040);
    key_ev(8'h1C, 1'b1, 1'b0);
    tick(2);
    check_eq("p1_fireA_btn", btn, 32'h04040);
    check_eq("p1_fireA_any", btn_any, 32'h050);
    key_ev(8'h29, 1'b0, 1'b0);
    tick(2);
    check_eq("p0_fireC_rel_btn", btn, 32'h04000);
    check_eq("p0_fireC_rel_any", btn_any, 32'h010);
    key_ev(8'h1C, 1'b0, 1'b0);
    tick(2);
    check_eq("p1_fireA_rel_btn", btn, 32'h0);
    check_eq("p1_fireA_rel_any", btn_any, 32'h0);

    // Extended keypad 8 aliases up; unmapped code changes nothing
    key_ev(8'h75, 1'b1, 1'b1);
    tick(2);
    check_eq("ext_up_alias", btn, 32'h00008);
    key_ev(8'h99, 1'b1, 1'b0);
    tick(2);
    check_eq("unmapped_ignored", btn, 32'h00008);
    key_ev(8'h75, 1'b0, 1'b1);
    tick(2);
    check_eq("ext_up_release", btn, 32'h0);

    // Joystick: p0 up and p1 right, one edge latency
    joy = 32'h0001_0008;
    tick(1);
    check_eq("joy_latency_1edge", btn, 32'h00408);
    joy = 32'h0;
    tick(1);
    check_eq("joy_release", btn, 32'h0);

    // Coin: long hold gives a 4-cycle pulse, then re-arm after release
    joy = 32'h400;
    count_coin(20, hi);
    check_eq("coin_hold_width", hi, 32'd4);
    joy = 32'h0;
    count_coin(5, hi);
    check_eq("coin_release_quiet", hi, 32'd0);
    joy = 32'h400;
    count_coin(10, hi);
    check_eq("coin_second_pulse", hi, 32'd4);
    joy = 32'h0;
    tick(3);

    // Coin: release and re-press inside the pulse does not extend it
    joy = 32'h400;
    count_coin(2, h1);
    joy = 32'h0;
    count_coin(1, h2);
    joy = 32'h400;
    count_coin(1, h3);
    joy = 32'h0;
    count_coin(10, h4);
    check_eq("coin_no_extend", h1 + h2 + h3 + h4, 32'd4);

    // Autofire on player 0 fireA: runs of 3 cycles
    af_en = 2'b01;
    key_ev(8'h14, 1'b1, 1'b0);
    tick(2);
    prev  = btn[4];
    found = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (btn[4] != prev) begin
        found = 1;
        break;
      end
      prev = btn[4];
    end
    check_eq("af_transition_seen", found, 32'd1);
    v = btn[4];
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp_b = (((k / 3) % 2) == 0) ? v : ~v;
      check_eq("af_period", btn[4], exp_b);
    end
    af_en = 2'b00;
    tick(1);
    check_eq("af_off_next_edge", btn[4], 32'h1);
    tick(1);
    check_eq("af_off_steady", btn[4], 32'h1);
    key_ev(8'h14, 1'b0, 1'b0);
    tick(2);
    check_eq("fireA_release", btn, 32'h0);

    // kbd_clear wins over a simultaneous release event; next event still decodes
    key_ev(8'h75, 1'b1, 1'b0);
    tick(2);
    key_ev(8'h72, 1'b1, 1'b0);
    tick(2);
    check_eq("up_down_held", btn, 32'h0000C);
    key_ev(8'h72, 1'b0, 1'b0);
    kbd_clear = 1'b1;
    tick(1);
    kbd_clear = 1'b0;
    tick(1);
    check_eq("kbd_clear_btn", btn, 32'h0);
    check_eq("kbd_clear_any", btn_any, 32'h0);
    key_ev(8'h6B, 1'b1, 1'b0);
    tick(2);
    check_eq("event_after_clear", btn, 32'h00002);
    key_ev(8'h6B, 1'b0, 1'b0);
    tick(2);

    // Asynchronous reset in the middle of a coin pulse
    joy = 32'h400;
    tick(2);
    check_eq("coin_before_reset", btn[9], 32'h1);
    #2 Rst_n = 1'b0;
    #1;
    check_eq("async_reset_btn", btn, 32'h0);
    check_eq("async_reset_any", btn_any, 32'h0);
    #3 Rst_n = 1'b1;
    count_coin(10, hi);
    check_eq("coin_after_reset", hi, 32'd4);
    joy = 32'h0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
